// File: rtl/texel_fetch_sequencer_pkg.sv
// Shared encodings for the texel fetch sequencer: FSM states, fetch modes, last-index values.
// Default data/coordinate/address widths live here so the top and address generator agree.
package texel_fetch_sequencer_pkg;

  localparam int TFS_ROW_W   = 96;
  localparam int TFS_COORD_W = 16;
  localparam int TFS_ADDR_W  = 32;

  typedef enum logic [1:0] {
    TFS_IDLE = 2'd0,
    TFS_ADDR = 2'd1,
    TFS_REQ  = 2'd2,
    TFS_DONE = 2'd3
  } tfs_state_e;

  localparam logic TFS_MODE_SINGLE = 1'b0;
  localparam logic TFS_MODE_QUAD   = 1'b1;

  localparam logic [1:0] TFS_LAST_SINGLE = 2'd0;
  localparam logic [1:0] TFS_LAST_QUAD   = 2'd3;

  function automatic logic [1:0] tfs_last_index(input logic quad);
    return (quad == TFS_MODE_QUAD) ? TFS_LAST_QUAD : TFS_LAST_SINGLE;
  endfunction

endpackage

// File: rtl/tfs_address_gen.sv
// Neighbour-coordinate select and linear address (base + y*width + x), registered on load_i.
// Edge policy is clamp-to-edge, or repeat addressing when THEIA_TFS_TEXWRAP_EN is defined.
module tfs_address_gen
  import texel_fetch_sequencer_pkg::*;
#(
  parameter int COORD_W = TFS_COORD_W,
  parameter int ADDR_W  = TFS_ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [1:0]         index_i,
  input  logic [COORD_W-1:0] u_i,
  input  logic [COORD_W-1:0] v_i,
  input  logic [COORD_W-1:0] width_i,
  input  logic [COORD_W-1:0] height_i,
  input  logic [ADDR_W-1:0]  base_i,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam logic [COORD_W-1:0] C_ONE = 1;

  logic [COORD_W:0]     u_inc, v_inc;
  logic [COORD_W-1:0]   u_nb, v_nb, x, y;
  logic [2*COORD_W-1:0] row_off;
  logic [ADDR_W-1:0]    addr_d, addr_q;

  always_comb begin
    // One extra bit so u+1 at the top of the coordinate range cannot alias to 0.
    u_inc = {1'b0, u_i} + {1'b0, C_ONE};
    v_inc = {1'b0, v_i} + {1'b0, C_ONE};
`ifdef THEIA_TFS_TEXWRAP_EN
    u_nb = (u_inc >= {1'b0, width_i})  ? '0 : u_inc[COORD_W-1:0];
    v_nb = (v_inc >= {1'b0, height_i}) ? '0 : v_inc[COORD_W-1:0];
`else
    u_nb = (u_inc >= {1'b0, width_i})  ? width_i - C_ONE  : u_inc[COORD_W-1:0];
    v_nb = (v_inc >= {1'b0, height_i}) ? height_i - C_ONE : v_inc[COORD_W-1:0];
`endif
    x       = index_i[0] ? u_nb : u_i;
    y       = index_i[1] ? v_nb : v_i;
    row_off = {{COORD_W{1'b0}}, y} * {{COORD_W{1'b0}}, width_i};
    addr_d  = base_i + ADDR_W'(row_off) + ADDR_W'(x);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/texel_fetch_sequencer.sv
// Fetches one texel or a 2x2 quad from TMEM, one request at a time, and presents all rows with a done pulse.
// Neighbour edge handling: clamp by default, wrap when THEIA_TFS_TEXWRAP_EN is defined.
module texel_fetch_sequencer
  import texel_fetch_sequencer_pkg::*;
#(
  parameter int ROW_W   = TFS_ROW_W,
  parameter int COORD_W = TFS_COORD_W,
  parameter int ADDR_W  = TFS_ADDR_W
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iQuad,
  input  logic [COORD_W-1:0] iU,
  input  logic [COORD_W-1:0] iV,
  input  logic [COORD_W-1:0] iTexWidth,
  input  logic [COORD_W-1:0] iTexHeight,
  input  logic [ADDR_W-1:0]  iTexBase,
  output logic               oTMEMDataRequest,
  output logic [ROW_W-1:0]   oTMEMReadAddress,
  input  logic               iTMEMDataAvailable,
  input  logic [ROW_W-1:0]   iTMEMReadData,
  output logic [ROW_W-1:0]   oTexel0,
  output logic [ROW_W-1:0]   oTexel1,
  output logic [ROW_W-1:0]   oTexel2,
  output logic [ROW_W-1:0]   oTexel3,
  output logic               oBusy,
  output logic               oDone
);

  tfs_state_e         state_q;
  logic               quad_q;
  logic [COORD_W-1:0] u_q, v_q, w_q, h_q;
  logic [ADDR_W-1:0]  base_q;
  logic [1:0]         idx_q;
  logic               req_q, busy_q, done_q;
  logic [ROW_W-1:0]   texel_q [4];
  logic [ADDR_W-1:0]  addr;

  tfs_address_gen #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .load_i   (state_q == TFS_ADDR),
    .index_i  (idx_q),
    .u_i      (u_q),
    .v_i      (v_q),
    .width_i  (w_q),
    .height_i (h_q),
    .base_i   (base_q),
    .addr_o   (addr)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= TFS_IDLE;
      quad_q  <= TFS_MODE_SINGLE;
      u_q     <= '0;
      v_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) texel_q[i] <= '0;
    end else begin
      case (state_q)
        TFS_IDLE: begin
          done_q <= 1'b0;
          if (iStart) begin
            quad_q  <= iQuad;
            u_q     <= iU;
            v_q     <= iV;
            w_q     <= iTexWidth;
            h_q     <= iTexHeight;
            base_q  <= iTexBase;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= TFS_ADDR;
          end
        end
        // Address register loads this cycle, so the request rises together with it.
        TFS_ADDR: begin
          req_q   <= 1'b1;
          state_q <= TFS_REQ;
        end
        TFS_REQ: begin
          if (iTMEMDataAvailable) begin
            texel_q[idx_q] <= iTMEMReadData;
            req_q          <= 1'b0;
            if (idx_q == tfs_last_index(quad_q)) begin
              done_q  <= 1'b1;
              state_q <= TFS_DONE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= TFS_ADDR;
            end
          end
        end
        TFS_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= TFS_IDLE;
        end
        default: state_q <= TFS_IDLE;
      endcase
    end
  end

  assign oTMEMDataRequest = req_q;
  assign oTMEMReadAddress = {{(ROW_W-ADDR_W){1'b0}}, addr};
  assign oTexel0          = texel_q[0];
  assign oTexel1          = texel_q[1];
  assign oTexel2          = texel_q[2];
  assign oTexel3          = texel_q[3];
  assign oBusy            = busy_q;
  assign oDone            = done_q;

endmodule

// File: tb/tb_texel_fetch_sequencer.sv
// Directed bench for texel_fetch_sequencer: vector table plus protocol and mid-operation reset sequences.
// Expected addresses for edge vectors follow THEIA_TFS_TEXWRAP_EN when it is defined.
module tb_texel_fetch_sequencer;

  typedef struct packed {
    logic             quad;
    logic [15:0]      u;
    logic [15:0]      v;
    logic [15:0]      w;
    logic [15:0]      h;
    logic [31:0]      base;
    logic [3:0]       lat;
    logic [3:0][31:0] addr;
  } vec_t;

  logic        Clock, Reset, iStart, iQuad;
  logic [15:0] iU, iV, iTexWidth, iTexHeight;
  logic [31:0] iTexBase;
  logic        oTMEMDataRequest, iTMEMDataAvailable, oBusy, oDone;
  logic [95:0] oTMEMReadAddress, iTMEMReadData;
  logic [95:0] oTexel0, oTexel1, oTexel2, oTexel3;
  logic [95:0] tex_o [4];

  logic        resp_avail, spur_avail;
  logic [95:0] resp_data, spur_data;
  int          resp_lat, resp_limit, n_req, gap_err, hold_err, done_cnt, cyc, start_cyc;
  logic [31:0] salt;
  logic [95:0] alog [64];
  logic [95:0] cur;
  logic        req_prev;
  logic [95:0] exp_tex [4];
  vec_t        vecs [6];
  int          checks, failures;

  assign iTMEMDataAvailable = resp_avail | spur_avail;
  assign iTMEMReadData      = resp_avail ? resp_data : spur_data;
  assign tex_o[0] = oTexel0;
  assign tex_o[1] = oTexel1;
  assign tex_o[2] = oTexel2;
  assign tex_o[3] = oTexel3;

  texel_fetch_sequencer dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .iStart             (iStart),
    .iQuad              (iQuad),
    .iU                 (iU),
    .iV                 (iV),
    .iTexWidth          (iTexWidth),
    .iTexHeight         (iTexHeight),
    .iTexBase           (iTexBase),
    .oTMEMDataRequest   (oTMEMDataRequest),
    .oTMEMReadAddress   (oTMEMReadAddress),
    .iTMEMDataAvailable (iTMEMDataAvailable),
    .iTMEMReadData      (iTMEMReadData),
    .oTexel0            (oTexel0),
    .oTexel1            (oTexel1),
    .oTexel2            (oTexel2),
    .oTexel3            (oTexel3),
    .oBusy              (oBusy),
    .oDone              (oDone)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clock);
      cyc++;
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge Clock);
      if (oDone === 1'b1) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  function automatic logic [95:0] row_of(input logic [31:0] a, input logic [31:0] s);
    return {s, ~a, a};
  endfunction

  function automatic vec_t mkvec(input logic q, input logic [15:0] u, v, w, h,
                                 input logic [31:0] base, input logic [3:0] lat,
                                 input logic [31:0] a0, a1, a2, a3);
    vec_t r;
    r.quad = q; r.u = u; r.v = v; r.w = w; r.h = h;
    r.base = base; r.lat = lat;
    r.addr[0] = a0; r.addr[1] = a1; r.addr[2] = a2; r.addr[3] = a3;
    return r;
  endfunction

  // TMEM model: answers each new request after resp_lat cycles with a row tagged by its address.
  initial begin
    resp_avail = 1'b0; resp_data = '0; req_prev = 1'b0;
    n_req = 0; gap_err = 0; hold_err = 0;
    forever begin
      @(posedge Clock); #1;
      if (oTMEMDataRequest === 1'b1 && !req_prev) begin
        cur = oTMEMReadAddress;
        if (n_req < 64) alog[n_req] = cur;
        n_req++;
        if (n_req <= resp_limit) begin
          for (int i = 0; i < resp_lat; i++) begin
            @(posedge Clock); #1;
            if (oTMEMDataRequest !== 1'b1 || oTMEMReadAddress !== cur) hold_err++;
          end
          resp_avail = 1'b1;
          resp_data  = row_of(cur[31:0], salt);
          @(posedge Clock); #1;
          resp_avail = 1'b0;
          resp_data  = '0;
          if (oTMEMDataRequest !== 1'b0) gap_err++;
        end
      end
      req_prev = oTMEMDataRequest;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
    end
  endtask

  task automatic start_cmd(input vec_t vv);
    iQuad = vv.quad; iU = vv.u; iV = vv.v;
    iTexWidth = vv.w; iTexHeight = vv.h; iTexBase = vv.base;
    iStart = 1'b1;
    start_cyc = cyc;
    @(posedge Clock); #1;
    iStart = 1'b0;
    iQuad = ~vv.quad; iU = ~vv.u; iV = ~vv.v;
    iTexWidth = ~vv.w; iTexHeight = ~vv.h; iTexBase = ~vv.base;
    chk("busy_after_start", oBusy, 1'b1);
    chk("req_low_in_addr", oTMEMDataRequest, 1'b0);
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    while (oDone !== 1'b1 && n < 300) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("done_seen", oDone, 1'b1);
    dc = cyc;
  endtask

  task automatic check_result(input vec_t vv, input int k, input int n0, input int d0, input int dc);
    int n;
    n = vv.quad ? 4 : 1;
    chk($sformatf("v%0d_latency", k), dc - start_cyc, n * (vv.lat + 2) + 1);
    @(posedge Clock); #1;
    chk($sformatf("v%0d_busy_idle", k), oBusy, 1'b0);
    chk($sformatf("v%0d_done_low", k), oDone, 1'b0);
    repeat (3) begin @(posedge Clock); #1; end
    chk($sformatf("v%0d_done_count", k), done_cnt - d0, 1);
    chk($sformatf("v%0d_req_count", k), n_req - n0, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("v%0d_addr%0d", k, i), alog[n0 + i], {64'd0, vv.addr[i]});
      exp_tex[i] = row_of(vv.addr[i], salt);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("v%0d_texel%0d", k, i), tex_o[i], exp_tex[i]);
    chk($sformatf("v%0d_gap", k), gap_err, 0);
    chk($sformatf("v%0d_hold", k), hold_err, 0);
  endtask

  task automatic run_vec(input vec_t vv, input int k);
    int n0, d0, dc;
    n0 = n_req; d0 = done_cnt;
    salt = 32'hA000_0000 + k;
    resp_lat = vv.lat;
    start_cmd(vv);
    wait_done(dc);
    check_result(vv, k, n0, d0, dc);
  endtask

  initial begin
    vec_t pv, rv;
    int   n0, d0, dc, n;
    checks = 0; failures = 0;
    Reset = 1'b1; iStart = 1'b0; iQuad = 1'b0;
    iU = '0; iV = '0; iTexWidth = '0; iTexHeight = '0; iTexBase = '0;
    spur_avail = 1'b0; spur_data = '0;
    resp_lat = 0; resp_limit = 1000; salt = '0;
    for (int i = 0; i < 4; i++) exp_tex[i] = '0;

    vecs[0] = mkvec(1'b0, 16'd3, 16'd2, 16'd8, 16'd8, 32'h100, 4'd3, 32'h113, 32'h0, 32'h0, 32'h0);
    vecs[1] = mkvec(1'b1, 16'd3, 16'd2, 16'd8, 16'd8, 32'h100, 4'd2, 32'h113, 32'h114, 32'h11B, 32'h11C);
`ifdef THEIA_TFS_TEXWRAP_EN
    vecs[2] = mkvec(1'b1, 16'd7, 16'd7, 16'd8, 16'd8, 32'h0, 4'd0, 32'd63, 32'd56, 32'd7, 32'd0);
    vecs[5] = mkvec(1'b1, 16'd5, 16'd9, 16'd10, 16'd10, 32'h1000, 4'd5, 32'h105F, 32'h1060, 32'h1005, 32'h1006);
`else
    vecs[2] = mkvec(1'b1, 16'd7, 16'd7, 16'd8, 16'd8, 32'h0, 4'd0, 32'd63, 32'd63, 32'd63, 32'd63);
    vecs[5] = mkvec(1'b1, 16'd5, 16'd9, 16'd10, 16'd10, 32'h1000, 4'd5, 32'h105F, 32'h1060, 32'h105F, 32'h1060);
`endif
    vecs[3] = mkvec(1'b1, 16'd0, 16'd0, 16'd1, 16'd1, 32'h40, 4'd1, 32'h40, 32'h40, 32'h40, 32'h40);
    vecs[4] = mkvec(1'b0, 16'd299, 16'd299, 16'd300, 16'd300, 32'hFFFF_FFF0, 4'd0, 32'h15F7F, 32'h0, 32'h0, 32'h0);

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_req", oTMEMDataRequest, 1'b0);
    chk("rst_addr", oTMEMReadAddress, 96'd0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_done", oDone, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_texel%0d", i), tex_o[i], 96'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Spurious available during ADDR, and restart strobes during REQ and DONE.
    pv = mkvec(1'b1, 16'd3, 16'd2, 16'd8, 16'd8, 32'h100, 4'd4, 32'h113, 32'h114, 32'h11B, 32'h11C);
    n0 = n_req; d0 = done_cnt;
    salt = 32'hB00B_0000;
    resp_lat = 4;
    start_cmd(pv);
    spur_avail = 1'b1; spur_data = {96{1'b1}};
    @(posedge Clock); #1;
    spur_avail = 1'b0; spur_data = '0;
    iStart = 1'b1; iQuad = 1'b0; iU = 16'd0; iV = 16'd0;
    @(posedge Clock); #1;
    iStart = 1'b0;
    wait_done(dc);
    iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    chk("proto_no_restart_busy", oBusy, 1'b0);
    chk("proto_latency", dc - start_cyc, 25);
    repeat (4) begin @(posedge Clock); #1; end
    chk("proto_done_count", done_cnt - d0, 1);
    chk("proto_req_count", n_req - n0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("proto_addr%0d", i), alog[n0 + i], {64'd0, pv.addr[i]});
      chk($sformatf("proto_texel%0d", i), tex_o[i], row_of(pv.addr[i], salt));
    end

    // Reset while texel 2 is outstanding, then a fresh single fetch.
    rv = mkvec(1'b1, 16'd3, 16'd2, 16'd8, 16'd8, 32'h200, 4'd1, 32'h213, 32'h214, 32'h21B, 32'h21C);
    n0 = n_req;
    resp_limit = n0 + 2;
    salt = 32'hC0DE_0000;
    resp_lat = 1;
    start_cmd(rv);
    n = 0;
    while (n_req - n0 < 3 && n < 100) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("rstmid_reached_req2", n_req - n0, 3);
    chk("rstmid_pre_req", oTMEMDataRequest, 1'b1);
    chk("rstmid_pre_addr", oTMEMReadAddress, {64'd0, 32'h21B});
    chk("rstmid_pre_texel1", oTexel1, row_of(32'h214, salt));
    #2;
    Reset = 1'b1;
    #1;
    chk("rstmid_req", oTMEMDataRequest, 1'b0);
    chk("rstmid_busy", oBusy, 1'b0);
    chk("rstmid_addr", oTMEMReadAddress, 96'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rstmid_texel%0d", i), tex_o[i], 96'd0);
    @(posedge Clock); #3;
    Reset = 1'b0;
    resp_limit = 1000;
    for (int i = 0; i < 4; i++) exp_tex[i] = '0;
    @(posedge Clock); #1;
    run_vec(mkvec(1'b0, 16'd1, 16'd1, 16'd4, 16'd4, 32'h20, 4'd2, 32'h25, 32'h0, 32'h0, 32'h0), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
